// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared constants and queue entry type for the fetch stage
package riscv_fetch_pkg;

    localparam int ILEN    = 32;
    localparam int PC_STEP = 4;

    localparam logic [ILEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] align_word(input logic [ILEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetch entries with flush; flush beats push
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, 1-cycle imem requests, tagged fetch queue
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]   pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          halted;
    logic          pop;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [31:0]   target;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign target = align_word(redirect_pc);
    assign pop    = if_valid & if_ready;

    // Reserve a slot for every outstanding request so a response can always be captured.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign imem_req  = !reset && !redirect_valid && !halted && (occupancy < (CW + 1)'(QDEPTH));
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= target;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= pc;
                pc          <= pc + 32'(PC_STEP);
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            halted      <= (redirect_pc[1:0] != 2'b00);
            fetch_fault <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign halted = 1'b0;
`endif

    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_rdata;

    // A redirect flushes the queue; inside the queue flush wins over the capture and the pop.
    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign if_valid = (count != '0);
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed timing checks
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    // Instruction memory: 1-cycle read returning addr << 4; junk when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? {imem_addr[27:0], 4'h0} : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted entry must be the next expected PC with its memory word.
    always @(negedge clk) begin
        if (!reset && !redirect_valid && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got pc %h expected none (cycle %0d)", if_pc, cyc);
            end else begin
                exp_pc = exp_q.pop_front();
                check("deliv_pc", if_pc, exp_pc);
                check("deliv_instr", if_instr, {exp_pc[27:0], 4'h0});
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int n);
        while (cyc < n) next();
    endtask

    task automatic start(input logic rdy);
        next();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = rdy;
        next();
        #2;
        check_bit("rst_if_valid", if_valid, 1'b0);
        check_bit("rst_imem_req", imem_req, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        next();
        reset = 1'b0;
        cyc   = 0;
        #2;
        check_bit("c0_imem_req", imem_req, 1'b1);
        check("c0_imem_addr", imem_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;

        // Streaming with decode always ready: one entry per cycle from cycle 2.
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
        start(1'b1);
        at(1); #2;
        check_bit("A_c1_valid", if_valid, 1'b0);
        check("A_c1_addr", imem_addr, 32'h4);
        for (int c = 2; c <= 7; c++) begin
            at(c); #2;
            check_bit("A_stream_valid", if_valid, 1'b1);
        end
        at(8); if_ready = 1'b0;

        // Stall from cycle 2: head holds, requests stop once full, resume on pop.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        start(1'b1);
        at(2); if_ready = 1'b0; #2;
        check_bit("B_c2_req", imem_req, 1'b0);
        for (int c = 3; c <= 6; c++) begin
            at(c); #2;
            check("B_hold_pc", if_pc, 32'h0);
            check_bit("B_full_req", imem_req, 1'b0);
        end
        at(7); if_ready = 1'b1; #2;
        check_bit("B_resume_req", imem_req, 1'b1);
        check("B_resume_addr", imem_addr, 32'h8);
        at(9); #2;
        check_bit("B_c9_valid", if_valid, 1'b1);
        at(10); if_ready = 1'b0;

        // Redirect to 0x2C with a full queue.
        exp_q.push_back(32'h2C); exp_q.push_back(32'h30); exp_q.push_back(32'h34);
        start(1'b1);
        at(2); if_ready = 1'b0;
        at(6); redirect_valid = 1'b1; redirect_pc = 32'h2C; #2;
        check_bit("C_redir_req", imem_req, 1'b0);
        at(7); redirect_valid = 1'b0; if_ready = 1'b1; #2;
        check_bit("C_c7_valid", if_valid, 1'b0);
        check("C_c7_addr", imem_addr, 32'h2C);
        at(8); #2;
        check_bit("C_c8_valid", if_valid, 1'b0);
        at(9); #2;
        check("C_c9_pc", if_pc, 32'h2C);
        at(12); if_ready = 1'b0;

        // Redirect and pop in the same cycle: the flush wins.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        start(1'b1);
        at(4); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
        check_bit("D_pop_valid", if_valid, 1'b1);
        at(5); redirect_valid = 1'b0; #2;
        check_bit("D_c5_valid", if_valid, 1'b0);
        at(7); #2;
        check("D_c7_pc", if_pc, 32'h100);
        at(9); if_ready = 1'b0;

        // Reset while the request to 0x200 is in flight.
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        start(1'b1);
        at(2); redirect_valid = 1'b1; redirect_pc = 32'h200;
        at(3); redirect_valid = 1'b0; #2;
        check("E_c3_addr", imem_addr, 32'h200);
        at(4); reset = 1'b1; #2;
        check_bit("E_rst_req", imem_req, 1'b0);
        at(5); reset = 1'b0; #2;
        check_bit("E_c5_valid", if_valid, 1'b0);
        check("E_c5_addr", imem_addr, 32'h0);
        at(6); #2;
        check_bit("E_c6_valid", if_valid, 1'b0);
        at(7); #2;
        check("E_c7_pc", if_pc, 32'h0);
        at(9); if_ready = 1'b0;

        // Misaligned redirect to 0x46.
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
        start(1'b1);
        at(2); redirect_valid = 1'b1; redirect_pc = 32'h46;
        at(3); redirect_valid = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            at(c); #2;
            check_bit("F_halt_req", imem_req, 1'b0);
            check_bit("F_fault", fetch_fault, 1'b1);
        end
        at(13); redirect_valid = 1'b1; redirect_pc = 32'h40;
        at(14); redirect_valid = 1'b0; #2;
        check_bit("F_fault_clr", fetch_fault, 1'b0);
        check("F_c14_addr", imem_addr, 32'h40);
        at(16); #2;
        check("F_c16_pc", if_pc, 32'h40);
        at(18); if_ready = 1'b0;
`else
        exp_q.push_back(32'h44); exp_q.push_back(32'h48);
        start(1'b1);
        at(2); redirect_valid = 1'b1; redirect_pc = 32'h46;
        at(3); redirect_valid = 1'b0; #2;
        check("F_mask_addr", imem_addr, 32'h44);
        at(5); #2;
        check("F_c5_pc", if_pc, 32'h44);
        at(7); if_ready = 1'b0;
`endif

        repeat (4) next();
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
